dsc_mul_sched: RTL and testbench

Operand scheduler and result capture stage wrapped around `dsc_mul`.
- Accepts 8-bit operand pairs on a valid/ready input port.
- Drives the multiplier's `a`, `b`, `en` and local clear, waits for its `ov` completion flag, captures `z`, and presents the product with a per-operation cycle count on a valid/ready output port.
- Provides a zero-operand bypass and a watchdog timeout, so the rest of the datapath never waits on the serial stochastic multiplier unbounded.

---
 rtl/dsc_pkg.sv | 23 ++
 rtl/dsc_cyc_ctr.sv | 26 ++
 rtl/dsc_mul_sched.sv | 139 +++++++++++++
 tb/tb_dsc_mul_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared types and defaults for the dsc_mul operand scheduler.
// Holds the scheduler state encoding and the timeout bound derivation.
package dsc_pkg;

    localparam int NUM_BITS_DEF = 8;
    localparam int CYC_W_DEF    = 20;

    // Smallest legal timeout: one more than the longest stochastic run (2^(2*NUM_BITS)).
    function automatic int timeout_min(input int num_bits);
        return (1 << (2 * num_bits)) + 1;
    endfunction

    localparam int TIMEOUT_DEF = timeout_min(NUM_BITS_DEF) + 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } sched_state_t;

endpackage

// File: rtl/dsc_cyc_ctr.sv
// Saturating RUN-cycle counter with a fixed-limit compare used for the watchdog.
module dsc_cyc_ctr #(
    parameter int               CYC_W = 20,
    parameter logic [CYC_W-1:0] LIMIT = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CYC_W-1:0] cnt,
    output logic             at_limit
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CYC_W'(1);
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/dsc_mul_sched.sv
// Operand scheduler and result capture around the serial stochastic multiplier dsc_mul.
// Handshake: a transfer happens on a rising edge where valid && ready; in_ready/out_valid decode state only.
module dsc_mul_sched
    import dsc_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF,
    parameter int CYC_W    = CYC_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_BITS-1:0]   in_a,
    input  logic [NUM_BITS-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NUM_BITS-1:0] out_z,
    output logic [CYC_W-1:0]      out_cycles,
    output logic                  out_err,
    output logic [NUM_BITS-1:0]   mul_a,
    output logic [NUM_BITS-1:0]   mul_b,
    output logic                  mul_en,
    output logic                  mul_clr,
    input  logic [2*NUM_BITS-1:0] mul_z,
    input  logic                  mul_ov,
    output sched_state_t          dbg_state
);

    localparam logic [CYC_W-1:0] TO_LIMIT = CYC_W'(TIMEOUT - 1);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [CYC_W-1:0] cnt;
    logic             at_limit;
    logic             in_fire;
    logic             zero_op;
    logic             ov_run;
    logic             timeout_run;

    assign in_fire     = (state == IDLE) && in_valid;
    assign zero_op     = (in_a == '0) || (in_b == '0);
    assign ov_run      = (state == RUN) && mul_ov;
    // ov in the same cycle as the limit wins, so timeout requires !mul_ov
    assign timeout_run = (state == RUN) && !mul_ov && at_limit;
    assign dbg_state   = state;

    dsc_cyc_ctr #(
        .CYC_W (CYC_W),
        .LIMIT (TO_LIMIT)
    ) u_cyc_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == CLEAR),
        .en       (state == RUN),
        .cnt      (cnt),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = zero_op ? DONE : CLEAR;
            CLEAR:   state_nxt = RUN;
            RUN: begin
                if (mul_ov)        state_nxt = SETTLE;
                else if (at_limit) state_nxt = DONE;
            end
            SETTLE:  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_en    = 1'b0;
        mul_clr   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                mul_clr  = 1'b1;
            end
            CLEAR:   mul_clr = 1'b1;
            RUN:     mul_en  = 1'b1;
            SETTLE:  mul_clr = 1'b0;
            DONE: begin
                out_valid = 1'b1;
                mul_clr   = 1'b1;
            end
            default: mul_clr = 1'b1;
        endcase
    end

    // Operands only move on the input handshake; results only on bypass, settle or timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            out_z      <= '0;
            out_cycles <= '0;
            out_err    <= 1'b0;
        end else begin
            if (in_fire) begin
                mul_a <= in_a;
                mul_b <= in_b;
                if (zero_op) begin
                    out_z      <= '0;
                    out_cycles <= '0;
                    out_err    <= 1'b0;
                end
            end
            if (timeout_run) begin
                out_z      <= mul_z;
                out_cycles <= cnt;
                out_err    <= 1'b1;
            end
            if (state == SETTLE) begin
                out_z      <= mul_z;
                out_cycles <= cnt;
                out_err    <= 1'b0;
            end
        end
    end

    // ov_run is kept as a named term for checker binding on the completion path.
    logic ov_seen_unused;
    assign ov_seen_unused = ov_run;

endmodule

// File: tb/tb_dsc_mul_sched.sv
// Directed bench for dsc_mul_sched: a behavioural multiplier model with a bench-set run
// length, plus a second instance with TIMEOUT=50 and a stub that never or barely finishes.
module tb_dsc_mul_sched;
  import dsc_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // main instance
  logic         in_valid, in_ready, out_valid, out_ready, out_err;
  logic         mul_en, mul_clr, mul_ov;
  logic [7:0]   in_a, in_b, mul_a, mul_b;
  logic [15:0]  out_z, mul_z;
  logic [19:0]  out_cycles;
  sched_state_t dbg_state;

  // timeout instance
  logic         t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_out_err;
  logic         t_mul_en, t_mul_clr, t_mul_ov;
  logic [7:0]   t_in_a, t_in_b, t_mul_a, t_mul_b;
  logic [15:0]  t_out_z, t_mul_z;
  logic [19:0]  t_out_cycles;
  sched_state_t t_dbg_state;

  dsc_mul_sched u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_cycles(out_cycles), .out_err(out_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_clr(mul_clr),
    .mul_z(mul_z), .mul_ov(mul_ov), .dbg_state(dbg_state)
  );

  dsc_mul_sched #(.NUM_BITS(8), .CYC_W(20), .TIMEOUT(50)) u_dut_to (
    .clk(clk), .rst(rst),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_a(t_in_a), .in_b(t_in_b),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_z(t_out_z),
    .out_cycles(t_out_cycles), .out_err(t_out_err),
    .mul_a(t_mul_a), .mul_b(t_mul_b), .mul_en(t_mul_en), .mul_clr(t_mul_clr),
    .mul_z(t_mul_z), .mul_ov(t_mul_ov), .dbg_state(t_dbg_state)
  );

  // multiplier model: finishes on the m_lat-th enabled cycle after a clear
  int   m_lat = 1;
  int   m_cnt = 0;
  logic ov_force = 1'b0;
  always @(posedge clk) begin
    if (mul_clr) m_cnt <= 0;
    else if (mul_en) m_cnt <= m_cnt + 1;
  end
  assign mul_ov = (mul_en && (m_cnt == m_lat - 1)) || ov_force;
  assign mul_z  = mul_clr ? 16'd0 : ({8'd0, mul_a} * {8'd0, mul_b});

  // stub: t_lat == 0 never finishes
  int t_lat = 0;
  int t_cnt = 0;
  always @(posedge clk) begin
    if (t_mul_clr) t_cnt <= 0;
    else if (t_mul_en) t_cnt <= t_cnt + 1;
  end
  assign t_mul_ov = t_mul_en && (t_lat != 0) && (t_cnt == t_lat - 1);
  assign t_mul_z  = 16'hBEEF;

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver: one input handshake, then wait (bounded) for out_valid
  task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int en_cycles);
    @(negedge clk);
    if (sel) begin t_in_a = a; t_in_b = b; t_in_valid = 1'b1; end
    else     begin in_a = a;   in_b = b;   in_valid = 1'b1;   end
    check("in_ready_at_send", sel ? t_in_ready : in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    t_in_valid = 1'b0;
    lat = 1;
    en_cycles = 0;
    while (!(sel ? t_out_valid : out_valid) && lat < 70000) begin
      if (sel ? t_mul_en : mul_en) en_cycles++;
      @(negedge clk);
      lat++;
    end
    check("result_arrived", sel ? t_out_valid : out_valid, 1);
  endtask

  task automatic release_out(input bit sel);
    if (sel) t_out_ready = 1'b1; else out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    t_out_ready = 1'b0;
    check("idle_after_release", sel ? t_dbg_state : dbg_state, IDLE);
    check("out_valid_dropped", sel ? t_out_valid : out_valid, 0);
  endtask

  int lat, enc;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    t_in_valid = 1'b0; t_in_a = '0; t_in_b = '0; t_out_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_state", dbg_state, IDLE);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_mul_clr", mul_clr, 1);
    check("rst_mul_en", mul_en, 0);
    check("rst_out_z", out_z, 0);
    check("rst_out_cycles", out_cycles, 0);
    check("rst_out_err", out_err, 0);
    check("rst_mul_ab", {mul_a, mul_b}, 0);
    rst = 1'b1;

    // 15 x 15, 256 run cycles
    m_lat = 256;
    run_op(0, 8'd15, 8'd15, lat, enc);
    check("z_15x15", out_z, 225);
    check("err_15x15", out_err, 0);
    check("cyc_15x15", out_cycles, 256);
    check("cyc_vs_en_15x15", out_cycles, enc);
    check("lat_15x15", lat, 256 + 3);
    check("mul_a_held", mul_a, 15);
    check("in_ready_done", in_ready, 0);
    check("mul_clr_done", mul_clr, 1);
    release_out(0);

    // zero-operand bypass
    run_op(0, 8'd0, 8'd200, lat, enc);
    check("lat_bypass", lat, 1);
    check("en_bypass", enc, 0);
    check("z_bypass", out_z, 0);
    check("cyc_bypass", out_cycles, 0);
    check("err_bypass", out_err, 0);
    check("mul_b_bypass", mul_b, 200);
    release_out(0);

    // ov outside RUN is ignored
    ov_force = 1'b1;
    @(negedge clk);
    ov_force = 1'b0;
    check("ov_in_idle_state", dbg_state, IDLE);
    check("ov_in_idle_valid", out_valid, 0);

    // 3 x 7 with a stalled consumer, new operands offered during the stall
    m_lat = 21;
    run_op(0, 8'd3, 8'd7, lat, enc);
    check("z_3x7", out_z, 21);
    check("cyc_3x7", out_cycles, 21);
    in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_z", out_z, 21);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("stall_idle", dbg_state, IDLE);
    check("no_accept_on_result_hs", mul_a, 3);

    // 255 x 255, full-length run
    m_lat = 65536;
    run_op(0, 8'd255, 8'd255, lat, enc);
    check("z_255x255", out_z, 65025);
    check("cyc_le_65536", out_cycles <= 20'd65536, 1);
    check("cyc_255x255", out_cycles, 65536);
    check("err_255x255", out_err, 0);
    check("lat_255x255", lat, 65536 + 3);
    release_out(0);

    // watchdog: stub never finishes, TIMEOUT=50
    t_lat = 0;
    run_op(1, 8'd1, 8'd1, lat, enc);
    check("to_err", t_out_err, 1);
    check("to_cyc", t_out_cycles, 49);
    check("to_z", t_out_z, 16'hBEEF);
    check("to_en", enc, 50);
    check("to_lat", lat, 52);
    release_out(1);

    // ov on the same cycle as the timeout limit: ov wins
    t_lat = 50;
    run_op(1, 8'd2, 8'd2, lat, enc);
    check("tie_err", t_out_err, 0);
    check("tie_cyc", t_out_cycles, 50);
    check("tie_z", t_out_z, 16'hBEEF);
    check("tie_lat", lat, 53);
    release_out(1);

    // reset mid-RUN
    m_lat = 1000;
    @(negedge clk);
    in_a = 8'd100; in_b = 8'd100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_run", dbg_state, RUN);
    rst = 1'b0;
    #1;
    check("mrst_state", dbg_state, IDLE);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_mul_clr", mul_clr, 1);
    check("mrst_mul_en", mul_en, 0);
    check("mrst_out_z", out_z, 0);
    check("mrst_out_cycles", out_cycles, 0);
    check("mrst_out_err", out_err, 0);
    check("mrst_mul_ab", {mul_a, mul_b}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    m_lat = 6;
    run_op(0, 8'd2, 8'd3, lat, enc);
    check("z_2x3", out_z, 6);
    check("cyc_2x3", out_cycles, 6);
    check("err_2x3", out_err, 0);
    check("lat_2x3", lat, 9);
    release_out(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
